ws281x_serializer: RTL and testbench

Parametrised single-wire serializer for WS2812B/SK6812-class LED chains, supporting 3-byte RGB and 4-byte RGBW pixels with per-part bit timing set at elaboration. Pixels are fetched from an upstream frame buffer over a request/valid handshake. The next pixel is prefetched while the current one shifts out. A late pixel aborts the frame cleanly and raises an underrun flag. It sits between the frame-buffer/SPI front end and the LED data pin.

---
 rtl/ws281x_serializer.sv | 192 +++++++++++++++++++
 tb/tb_ws281x_serializer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws281x_serializer.sv
// Single-wire WS2812B/SK6812 serializer: fetches GRB/GRBW pixels over req/valid,
// prefetches one pixel ahead, and aborts the frame into a latch on underrun.
module ws281x_serializer #(
  parameter  int NUM_LEDS      = 8,
  parameter  int BYTES_PER_LED = 3,
  parameter  int SYSTEM_CLOCK  = 50000000,
  parameter  int T0H_NS        = 300,
  parameter  int T1H_NS        = 600,
  parameter  int BIT_NS        = 1250,
  parameter  int RESET_NS      = 80000,
  localparam int AW            = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  localparam int PW            = 8 * BYTES_PER_LED
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [AW:0]   led_count_i,
  output logic          pixel_req_o,
  output logic [AW-1:0] pixel_addr_o,
  input  logic [PW-1:0] pixel_i,
  input  logic          pixel_valid_i,
  output logic          do_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          underrun_o
);
  localparam longint unsigned NS = 64'd1000000000;
  localparam int C_T0H = int'(64'(SYSTEM_CLOCK) * 64'(T0H_NS) / NS);
  localparam int C_T1H = int'(64'(SYSTEM_CLOCK) * 64'(T1H_NS) / NS);
  localparam int C_BIT = int'(64'(SYSTEM_CLOCK) * 64'(BIT_NS) / NS);
  localparam int C_RST = int'(64'(SYSTEM_CLOCK) * 64'(RESET_NS) / NS);
  localparam int CMAX  = (C_RST > C_BIT) ? C_RST : C_BIT;
  localparam int TW    = $clog2(CMAX + 1);
  localparam int BW    = $clog2(PW);

  localparam logic [TW-1:0] T0H_M1   = TW'(C_T0H - 1);
  localparam logic [TW-1:0] T1H_M1   = TW'(C_T1H - 1);
  localparam logic [TW-1:0] BIT_M1   = TW'(C_BIT - 1);
  localparam logic [TW-1:0] RST_M1   = TW'(C_RST - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PW - 1);
  localparam logic [AW:0]   ONE      = (AW+1)'(1);
  localparam logic [AW:0]   MAX_CNT  = (AW+1)'(NUM_LEDS);

  if (!(C_T0H >= 1 && C_T0H < C_T1H && C_T1H < C_BIT)) begin : g_bad_timing
    $error("ws281x_serializer: need 1 <= C_T0H < C_T1H < C_BIT");
  end

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HIGH, S_LOW, S_LATCH} state_t;

  state_t        state;
  logic          s1, s2, s2_d, pending_r;
  logic [AW:0]   cnt_r, cur_r;
  logic [AW-1:0] addr_r;
  logic [PW-1:0] shift_r, buf_r;
  logic          buf_full;
  logic [BW-1:0] bit_r;
  logic [TW-1:0] tmr;
  logic          do_r, req_r, busy_r, done_r, und_r;

  logic          rise, xfer;
  logic [AW:0]   cnt_in, nxt_addr;

  assign rise     = s2 & ~s2_d;
  assign xfer     = req_r & pixel_valid_i;
  assign cnt_in   = (led_count_i > MAX_CNT) ? MAX_CNT : led_count_i;
  assign nxt_addr = {1'b0, addr_r} + ONE;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= start_i;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= S_LATCH;
      pending_r <= 1'b0;
      cnt_r     <= '0;
      cur_r     <= '0;
      addr_r    <= '0;
      shift_r   <= '0;
      buf_r     <= '0;
      buf_full  <= 1'b0;
      bit_r     <= '0;
      tmr       <= '0;
      do_r      <= 1'b0;
      req_r     <= 1'b0;
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
      und_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      und_r  <= 1'b0;
      if (rise && state != S_IDLE) pending_r <= 1'b1;
      // Any accepted pixel lands in the prefetch buffer unless a state below consumes it directly.
      if (xfer) begin
        buf_r    <= pixel_i;
        buf_full <= 1'b1;
        req_r    <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          buf_full <= 1'b0;
          if (pending_r || rise) begin
            pending_r <= 1'b0;
            cnt_r     <= cnt_in;
            busy_r    <= 1'b1;
            tmr       <= '0;
            addr_r    <= '0;
            if (cnt_in == '0) state <= S_LATCH;
            else begin
              state <= S_FETCH;
              req_r <= 1'b1;
            end
          end
        end
        S_FETCH: if (xfer) begin
          shift_r  <= pixel_i;
          buf_full <= 1'b0;
          bit_r    <= '0;
          tmr      <= '0;
          cur_r    <= '0;
          do_r     <= 1'b1;
          state    <= S_HIGH;
          if (cnt_r > ONE) begin
            req_r  <= 1'b1;
            addr_r <= nxt_addr[AW-1:0];
          end
        end
        S_HIGH: begin
          tmr <= tmr + 1'b1;
          if (tmr == (shift_r[PW-1] ? T1H_M1 : T0H_M1)) begin
            do_r  <= 1'b0;
            state <= S_LOW;
          end
        end
        S_LOW: begin
          if (tmr != BIT_M1) tmr <= tmr + 1'b1;
          else begin
            tmr <= '0;
            if (bit_r != LAST_BIT) begin
              shift_r <= shift_r << 1;
              bit_r   <= bit_r + 1'b1;
              do_r    <= 1'b1;
              state   <= S_HIGH;
            end else if (cur_r + ONE == cnt_r) begin
              state <= S_LATCH;
            end else if (buf_full || xfer) begin
              // A transfer on the boundary cycle is still in time: bypass the buffer.
              shift_r  <= buf_full ? buf_r : pixel_i;
              buf_full <= 1'b0;
              cur_r    <= cur_r + ONE;
              bit_r    <= '0;
              do_r     <= 1'b1;
              state    <= S_HIGH;
              if (nxt_addr < cnt_r) begin
                req_r  <= 1'b1;
                addr_r <= nxt_addr[AW-1:0];
              end
            end else begin
              und_r <= 1'b1;
              req_r <= 1'b0;
              state <= S_LATCH;
            end
          end
        end
        S_LATCH: begin
          if (tmr == RST_M1) begin
            tmr    <= '0;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else tmr <= tmr + 1'b1;
        end
        default: state <= S_LATCH;
      endcase
    end
  end

  assign pixel_req_o  = req_r;
  assign pixel_addr_o = addr_r;
  assign do_o         = do_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign underrun_o   = und_r;
endmodule

// File: tb/tb_ws281x_serializer.sv
// Scoreboard bench for ws281x_serializer: stimulus queues expected high widths,
// monitors measure do_o pulses and bit periods and pop/compare.
module tb_ws281x_serializer;
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst, start, req, do_s, busy, done, und, vld;
  logic [3:0]  cnt;
  logic [2:0]  addr;
  logic [23:0] pix;
  logic [23:0] mem [8];
  logic [7:0]  ven;

  logic        start4, req4, do4, busy4, done4, und4, vld4;
  logic [1:0]  cnt4;
  logic [0:0]  addr4;
  logic [31:0] pix4;

  assign pix  = mem[addr];
  assign vld  = req & ven[addr];
  assign vld4 = req4;

  ws281x_serializer u_dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .led_count_i(cnt),
    .pixel_req_o(req), .pixel_addr_o(addr), .pixel_i(pix), .pixel_valid_i(vld),
    .do_o(do_s), .busy_o(busy), .done_o(done), .underrun_o(und)
  );

  ws281x_serializer #(.NUM_LEDS(1), .BYTES_PER_LED(4)) u_dut4 (
    .clk_i(clk), .reset_i(rst), .start_i(start4), .led_count_i(cnt4),
    .pixel_req_o(req4), .pixel_addr_o(addr4), .pixel_i(pix4), .pixel_valid_i(vld4),
    .do_o(do4), .busy_o(busy4), .done_o(done4), .underrun_o(und4)
  );

  int total = 0, bad = 0, cyc = 0;
  int exp_q[$], exp4[$];
  bit mon_en = 1'b1;
  int nbits = 0, last_rise = 0, und_n = 0, und_cyc = 0;
  int rise_t[64];
  int nbits4 = 0, lr4 = 0, wide4 = 0;
  logic prev_do = 1'b0, prev4 = 1'b0;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cyc %0d)", nm, cyc);
  endtask

  task automatic push_pix(input logic [23:0] p);
    for (int b = 23; b >= 0; b--) exp_q.push_back(p[b] ? 30 : 15);
  endtask

  task automatic wait_done(input string nm, input int lim, output int dc);
    dc = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin dc = cyc; break; end
    end
    if (dc < 0) fail({nm, " done timeout"});
  endtask

  // Raise start, record when the request appears and when do_o first rises.
  task automatic launch(output int s, output int rq, output int r0);
    @(negedge clk);
    s = cyc; rq = -1; r0 = -1;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req && rq < 0) rq = cyc;
      if (do_s) begin r0 = cyc; break; end
    end
    start = 1'b0;
    if (r0 < 0) fail("first bit timeout");
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    int w;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (do_s && !prev_do) begin
          if (nbits > 0) check("bit period", cyc - last_rise, 62);
          if (nbits < 64) rise_t[nbits] = cyc;
          last_rise = cyc;
          nbits++;
        end
        if (!do_s && prev_do) begin
          if (exp_q.size() == 0) fail("unexpected bit on do_o");
          else begin
            w = exp_q.pop_front();
            check("high width", cyc - last_rise, w);
          end
        end
        if (und) begin und_n++; und_cyc = cyc; end
      end
      prev_do = do_s;
    end
  end

  initial begin
    int w;
    forever begin
      @(negedge clk);
      if (do4 && !prev4) begin
        if (nbits4 > 0) check("rgbw bit period", cyc - lr4, 62);
        lr4 = cyc;
        nbits4++;
      end
      if (!do4 && prev4) begin
        if (exp4.size() == 0) fail("unexpected rgbw bit");
        else begin
          w = exp4.pop_front();
          check("rgbw high width", cyc - lr4, w);
          if (cyc - lr4 == 30) wide4++;
        end
      end
      prev4 = do4;
    end
  end

  initial begin
    #1800000;
    fail("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int s, rq, r0, dc, d1, d2, rel;
    logic [31:0] p4;
    rst = 1'b1; start = 1'b0; cnt = 4'd0; ven = 8'hFF;
    start4 = 1'b0; cnt4 = 2'd1; pix4 = 32'h80000001;
    for (int i = 0; i < 8; i++) mem[i] = 24'h0;

    // reset state
    #35;
    check("rst do_o", do_s, 0);
    check("rst busy_o", busy, 1);
    check("rst pixel_req_o", req, 0);
    check("rst pixel_addr_o", addr, 0);
    check("rst done_o", done, 0);
    check("rst underrun_o", und, 0);
    check("rst busy_o rgbw", busy4, 1);
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    wait_done("initial latch", 4100, dc);
    check("initial latch length", dc - rel, 4000);
    check("busy_o after latch", busy, 0);

    // two LEDs, always valid
    mem[0] = 24'hFF00A5; mem[1] = 24'h000001; cnt = 4'd2;
    nbits = 0; und_n = 0;
    push_pix(mem[0]); push_pix(mem[1]);
    launch(s, rq, r0);
    check("start to request", rq - s, 3);
    check("start to first bit", r0 - s, 4);
    wait_done("frame2", 8000, dc);
    check("frame2 bit count", nbits, 48);
    check("frame2 latch after last bit", dc - last_rise, 4062);
    check("frame2 queue drained", exp_q.size(), 0);
    check("frame2 no underrun", und_n, 0);
    check("frame2 busy low", busy, 0);

    // underrun on pixel 1 of 3
    mem[0] = 24'h5A3C96; mem[1] = 24'h111111; mem[2] = 24'h222222; cnt = 4'd3;
    ven[1] = 1'b0; nbits = 0; und_n = 0;
    push_pix(mem[0]);
    launch(s, rq, r0);
    wait_done("underrun", 6000, dc);
    check("underrun bit count", nbits, 24);
    check("underrun pulses", und_n, 1);
    check("underrun at boundary", und_cyc - last_rise, 62);
    check("underrun latch length", dc - last_rise, 4062);
    check("underrun req dropped", req, 0);
    check("underrun busy low", busy, 0);
    check("underrun queue drained", exp_q.size(), 0);
    ven[1] = 1'b1;

    // pixel 1 valid only on the final LOW cycle of pixel 0
    mem[0] = 24'h123456; mem[1] = 24'hABCDEF; cnt = 4'd2;
    ven[1] = 1'b0; nbits = 0; und_n = 0;
    push_pix(mem[0]); push_pix(mem[1]);
    launch(s, rq, r0);
    while (cyc < r0 + 1487) @(negedge clk);
    ven[1] = 1'b1;
    @(negedge clk);
    ven[1] = 1'b0;
    wait_done("late pixel", 8000, dc);
    check("late bit count", nbits, 48);
    check("late no underrun", und_n, 0);
    check("late bit24 start", rise_t[24] - r0, 1488);
    check("late queue drained", exp_q.size(), 0);
    ven[1] = 1'b1;

    // start edge mid-frame, second frame with zero LEDs
    mem[0] = 24'hC0FFEE; cnt = 4'd1; nbits = 0;
    push_pix(mem[0]);
    launch(s, rq, r0);
    repeat (100) @(negedge clk);
    start = 1'b1; cnt = 4'd0;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_done("queued first", 6000, d1);
    check("queued busy at done", busy, 0);
    @(negedge clk);
    check("queued second frame busy", busy, 1);
    wait_done("zero frame", 4100, d2);
    check("zero frame latch", d2 - d1, 4001);
    check("queued bit count", nbits, 24);
    check("queued queue drained", exp_q.size(), 0);

    // reset pulsed during a HIGH phase
    mem[0] = 24'hFFFFFF; cnt = 4'd1; mon_en = 1'b0;
    launch(s, rq, r0);
    repeat (5) @(negedge clk);
    check("do_o high before reset", do_s, 1);
    #3 rst = 1'b1;
    #1;
    check("async do_o", do_s, 0);
    check("mid rst busy_o", busy, 1);
    check("mid rst pixel_req_o", req, 0);
    check("mid rst pixel_addr_o", addr, 0);
    check("mid rst done_o", done, 0);
    check("mid rst underrun_o", und, 0);
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    nbits = 0; mon_en = 1'b1;
    repeat (2000) @(negedge clk);
    check("post rst busy_o", busy, 1);
    wait_done("post rst latch", 2100, dc);
    check("post rst latch length", dc - rel, 4000);
    check("post rst no bits", nbits, 0);

    // RGBW, one LED
    p4 = pix4;
    for (int b = 31; b >= 0; b--) exp4.push_back(p4[b] ? 30 : 15);
    nbits4 = 0; wide4 = 0;
    @(negedge clk);
    start4 = 1'b1;
    dc = -1;
    for (int i = 0; i < 7000; i++) begin
      @(negedge clk);
      if (i == 5) start4 = 1'b0;
      if (done4) begin dc = cyc; break; end
    end
    if (dc < 0) fail("rgbw done timeout");
    check("rgbw bit count", nbits4, 32);
    check("rgbw wide bits", wide4, 2);
    check("rgbw queue drained", exp4.size(), 0);
    check("rgbw latch length", dc - lr4, 4062);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
